servant_ram_arbiter: RTL and testbench
======================================

Name: servant_ram_arbiter

Overview:
- Sequences all accesses to the shared single-port servant RAM.
- Arbitrates between the CPU Wishbone port and the VPU load/store port, and generates a separate ack/read-data return to each requester.
- Replaces fixed VPU-override muxing with a granted, fair, one-access-at-a-time scheme.
- Sits between the servant CPU/VPU and the RAM macro, which has synchronous read with 1-cycle latency and byte-lane write enables.

Parameters:
- depth, 262144: RAM size in bytes.
- aw, $clog2(depth): byte address width.
- VPU, 1'b0: 1 = VPU port active; 0 = VPU inputs ignored, o_vpu_ack held 0.
- MAX_VPU_RUN, 4: maximum consecutive VPU grants while the CPU is waiting; range 1..255.

Ports:
- i_wb_clk, in, 1: sole clock.
- i_wb_rst_n, in, 1: asynchronous active-low reset.
- i_wb_adr, in, [aw-1:2]: CPU word address.
- i_wb_dat, in, 32: CPU write data.
- i_wb_sel, in, 4: CPU byte selects.
- i_wb_we, in, 1: CPU write.
- i_wb_cyc, in, 1: CPU request, level, held until ack.
- o_wb_rdt, out, 32: CPU read data, valid when o_wb_ack.
- o_wb_ack, out, 1: CPU ack, one-cycle pulse.
- i_vpu_request_rd, in, 1: VPU read request, level, held until ack.
- i_vpu_request_wr, in, 1: VPU write request, level, held until ack.
- i_vpu_adr, in, [aw-1:2]: VPU word address.
- i_vpu_dat, in, 32: VPU write data.
- i_vpu_sel, in, 4: VPU byte selects.
- o_vpu_rdt, out, 32: VPU read data, valid when o_vpu_ack.
- o_vpu_ack, out, 1: VPU ack, one-cycle pulse.
- o_ram_adr, out, [aw-1:2]: RAM word address.
- o_ram_dat, out, 32: RAM write data.
- o_ram_we, out, 4: RAM byte write enables.
- i_ram_rdt, in, 32: RAM registered read data.
- o_grant, out, 2: [0] = CPU owns RAM, [1] = VPU owns RAM (status/debug).

Behaviour:
- Requests: cpu_req = i_wb_cyc. vpu_req = VPU & (i_vpu_request_rd | i_vpu_request_wr).
- VPU rd and wr asserted together: treated as a write.
- States: IDLE, CPU_CMD, CPU_ACK, VPU_CMD, VPU_ACK; all are registered.
- IDLE:
  - Neither request pending: stay in IDLE.
  - Only one request pending: go to that requester's CMD state.
  - Both pending: VPU wins unless run_cnt == MAX_VPU_RUN, in which case CPU wins.
- CPU_CMD -> CPU_ACK, and VPU_CMD -> VPU_ACK, unconditionally.
- CPU_ACK / VPU_ACK -> IDLE, unconditionally. No back-to-back grant without passing through IDLE.
- RAM drive:
  - o_ram_adr/o_ram_dat come from the CPU inputs in CPU_* states and from the VPU inputs in VPU_* states.
  - In IDLE the last granted source is held.
  - o_ram_we = sel & {4{write}} only in a CMD state; 0 in every other state.
- Acks:
  - o_wb_ack = (state == CPU_ACK); o_vpu_ack = (state == VPU_ACK).
  - Each is decoded from the registered state, so it is glitch-free and exactly 1 cycle.
  - o_wb_rdt = o_vpu_rdt = i_ram_rdt, valid in the ack cycle. For a write, rdt is the pre-write word (don't-care).
- Latency: request present at edge 0 in IDLE -> CMD after edge 1 -> ack high after edge 2. Minimum is 2 cycles; a request is accepted at most once per 3 cycles.
- run_cnt (8 bit):
  - Reset to 0.
  - +1 on each IDLE->VPU_CMD transition taken while cpu_req = 1, saturating at MAX_VPU_RUN.
  - Cleared on IDLE->CPU_CMD, and on IDLE->VPU_CMD when cpu_req = 0.
- Withdrawal: a requester dropping its request during CMD/ACK does not abort the access. A write already issued completes; the ack is still pulsed.
- o_grant = {VPU_CMD|VPU_ACK, CPU_CMD|CPU_ACK}.
- Reset (asynchronous, any state): state = IDLE, run_cnt = 0, o_wb_ack = o_vpu_ack = 0, o_ram_we = 0, o_grant = 0, held source = CPU.
  - A write in flight at reset may or may not have reached RAM; no ack is issued for it.
- VPU = 0: VPU_* states are unreachable and the block reduces to a pure CPU sequencer.

Test Plan:
- CPU write then read: i_wb_cyc = 1, we = 1, adr = 0x10, dat = 0xDEADBEEF, sel = 0xF -> o_ram_we = 0xF for exactly one cycle, o_wb_ack on the 2nd edge. Read of 0x10 -> o_wb_rdt = 0xDEADBEEF with ack.
- Byte write: VPU wr, sel = 0x2, dat = 0x0000AB00 over 0xDEADBEEF -> o_ram_we = 0x2; CPU readback = 0xDEADABEF; o_vpu_ack pulses once.
- Simultaneous requests with MAX_VPU_RUN = 4, CPU and VPU held continuously -> grant order V,V,V,V,C,V,V,V,V,C. No starvation; acks never overlap.
- VPU rd + wr asserted together at adr 0x20, dat = 0x12345678 -> a single write with one ack; a following read returns 0x12345678.
- Async reset in CPU_CMD with a write pending -> o_ram_we and o_grant go to 0 immediately without a clock edge; no o_wb_ack. After release, the held request is re-served with 2-cycle latency.
- VPU = 0 with a VPU request held high and a CPU read -> o_vpu_ack stays 0 indefinitely; the CPU is served with 2-cycle latency.

Source files
------------

// File: rtl/servant_ram_arbiter_if.sv
// Bus bundle for the shared servant RAM arbiter: CPU Wishbone port, VPU
// load/store port, RAM macro port and grant status.
interface servant_ram_arbiter_if #(
  parameter int aw = 18
);
  logic [aw-1:2] i_wb_adr;
  logic [31:0]   i_wb_dat;
  logic [3:0]    i_wb_sel;
  logic          i_wb_we;
  logic          i_wb_cyc;
  logic [31:0]   o_wb_rdt;
  logic          o_wb_ack;

  logic          i_vpu_request_rd;
  logic          i_vpu_request_wr;
  logic [aw-1:2] i_vpu_adr;
  logic [31:0]   i_vpu_dat;
  logic [3:0]    i_vpu_sel;
  logic [31:0]   o_vpu_rdt;
  logic          o_vpu_ack;

  logic [aw-1:2] o_ram_adr;
  logic [31:0]   o_ram_dat;
  logic [3:0]    o_ram_we;
  logic [31:0]   i_ram_rdt;
  logic [1:0]    o_grant;

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
    output o_wb_rdt, o_wb_ack,
    input  i_vpu_request_rd, i_vpu_request_wr, i_vpu_adr, i_vpu_dat, i_vpu_sel,
    output o_vpu_rdt, o_vpu_ack,
    output o_ram_adr, o_ram_dat, o_ram_we,
    input  i_ram_rdt,
    output o_grant
  );

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
    input  o_wb_rdt, o_wb_ack,
    output i_vpu_request_rd, i_vpu_request_wr, i_vpu_adr, i_vpu_dat, i_vpu_sel,
    input  o_vpu_rdt, o_vpu_ack,
    input  o_ram_adr, o_ram_dat, o_ram_we,
    output i_ram_rdt,
    input  o_grant
  );
endinterface

// File: rtl/servant_ram_arbiter.sv
// One-access-at-a-time arbiter for the single-port servant RAM. VPU is favoured
// but yields to a waiting CPU after MAX_VPU_RUN consecutive grants.
module servant_ram_arbiter #(
  parameter int depth       = 262144,
  parameter int aw          = $clog2(depth),
  parameter bit VPU         = 1'b0,
  parameter int MAX_VPU_RUN = 4
) (
  input logic                  i_wb_clk,
  input logic                  i_wb_rst_n,
  servant_ram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CPU_CMD, CPU_ACK, VPU_CMD, VPU_ACK} state_e;

  typedef struct packed {
    logic [aw-1:2] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
  } ram_req_t;

  localparam logic [7:0] RunMax = 8'(MAX_VPU_RUN);

  if ((MAX_VPU_RUN < 1) || (MAX_VPU_RUN > 255) || ((1 << aw) < depth)) begin : g_bad_param
    $error("servant_ram_arbiter: illegal MAX_VPU_RUN or aw/depth");
  end

  state_e     state_q, state_d;
  logic [7:0] run_cnt_q, run_cnt_d;
  logic       src_vpu_q, src_vpu_d;

  logic     cpu_req, vpu_req, use_vpu, in_cmd;
  ram_req_t cpu_r, vpu_r, cur_r;

  assign cpu_req = bus.i_wb_cyc;
  assign vpu_req = VPU & (bus.i_vpu_request_rd | bus.i_vpu_request_wr);

  // rd+wr together collapses to a write
  assign cpu_r = '{adr: bus.i_wb_adr,  dat: bus.i_wb_dat,  sel: bus.i_wb_sel,  we: bus.i_wb_we};
  assign vpu_r = '{adr: bus.i_vpu_adr, dat: bus.i_vpu_dat, sel: bus.i_vpu_sel, we: bus.i_vpu_request_wr};

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q   <= IDLE;
      run_cnt_q <= 8'd0;
      src_vpu_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      src_vpu_q <= src_vpu_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    src_vpu_d = src_vpu_q;
    case (state_q)
      IDLE: begin
        if (vpu_req && (!cpu_req || (run_cnt_q != RunMax))) begin
          state_d   = VPU_CMD;
          src_vpu_d = 1'b1;
          // only runs taken against a waiting CPU count toward the fairness limit
          if (!cpu_req)                run_cnt_d = 8'd0;
          else if (run_cnt_q != RunMax) run_cnt_d = run_cnt_q + 8'd1;
        end else if (cpu_req) begin
          state_d   = CPU_CMD;
          src_vpu_d = 1'b0;
          run_cnt_d = 8'd0;
        end
      end
      CPU_CMD: state_d = CPU_ACK;
      VPU_CMD: state_d = VPU_ACK;
      default: state_d = IDLE;
    endcase
  end

  // IDLE keeps steering the RAM from whichever side was granted last
  assign use_vpu = (state_q == VPU_CMD) || (state_q == VPU_ACK) || ((state_q == IDLE) && src_vpu_q);
  assign in_cmd  = (state_q == CPU_CMD) || (state_q == VPU_CMD);
  assign cur_r   = use_vpu ? vpu_r : cpu_r;

  always_comb begin
    bus.o_ram_adr = cur_r.adr;
    bus.o_ram_dat = cur_r.dat;
    bus.o_ram_we  = in_cmd ? (cur_r.sel & {4{cur_r.we}}) : 4'd0;
    bus.o_wb_ack  = (state_q == CPU_ACK);
    bus.o_vpu_ack = (state_q == VPU_ACK);
    bus.o_wb_rdt  = bus.i_ram_rdt;
    bus.o_vpu_rdt = bus.i_ram_rdt;
    bus.o_grant   = {(state_q == VPU_CMD) || (state_q == VPU_ACK),
                     (state_q == CPU_CMD) || (state_q == CPU_ACK)};
  end

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Bench for servant_ram_arbiter: directed cases plus randomized CPU/VPU traffic
// scored against a word-level memory model.
module tb_servant_ram_arbiter;
  localparam int AW   = 10;
  localparam int MAXR = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   nchk  = 0;
  int   npass = 0;

  servant_ram_arbiter_if #(.aw(AW)) bus  ();
  servant_ram_arbiter_if #(.aw(AW)) bus0 ();

  servant_ram_arbiter #(.depth(1024), .aw(AW), .VPU(1'b1), .MAX_VPU_RUN(MAXR)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .bus(bus));
  servant_ram_arbiter #(.depth(1024), .aw(AW), .VPU(1'b0), .MAX_VPU_RUN(MAXR)) dut0 (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;

  // RAM macros: registered read of the pre-write word, byte-lane writes
  logic [31:0] ram  [0:255];
  logic [31:0] ram0 [0:255];
  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = '0; ram0[i] = '0; end
    forever begin
      @(posedge clk);
      for (int b = 0; b < 4; b++) begin
        if (bus.o_ram_we[b])  ram[bus.o_ram_adr][8*b +: 8]   <= bus.o_ram_dat[8*b +: 8];
        if (bus0.o_ram_we[b]) ram0[bus0.o_ram_adr][8*b +: 8] <= bus0.o_ram_dat[8*b +: 8];
      end
      bus.i_ram_rdt  <= ram[bus.o_ram_adr];
      bus0.i_ram_rdt <= ram0[bus0.o_ram_adr];
    end
  end

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Reference model: memory image updated in ack order, plus grant history
  logic [31:0] exp_mem [0:255];
  byte         glog[$];
  initial begin
    logic [1:0] pg;
    int vrun;
    pg = '0; vrun = 0;
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    forever begin
      @(posedge clk); #1;
      chk("ack_overlap", 32'(bus.o_wb_ack & bus.o_vpu_ack), 32'd0);
      chk("novpu_ack", 32'(bus0.o_vpu_ack), 32'd0);
      if (bus.o_wb_ack) begin
        if (bus.i_wb_we) exp_mem[bus.i_wb_adr] = merge(exp_mem[bus.i_wb_adr], bus.i_wb_dat, bus.i_wb_sel);
        else chk("cpu_rd_model", bus.o_wb_rdt, exp_mem[bus.i_wb_adr]);
      end
      if (bus.o_vpu_ack) begin
        if (bus.i_vpu_request_wr) exp_mem[bus.i_vpu_adr] = merge(exp_mem[bus.i_vpu_adr], bus.i_vpu_dat, bus.i_vpu_sel);
        else chk("vpu_rd_model", bus.o_vpu_rdt, exp_mem[bus.i_vpu_adr]);
      end
      if (bus.o_grant != 2'b00 && pg == 2'b00) begin
        if (bus.o_grant[1]) begin
          glog.push_back(8'h56);
          vrun = bus.i_wb_cyc ? vrun + 1 : 0;
          chk("fair_run", 32'(vrun <= MAXR), 32'd1);
        end else begin
          glog.push_back(8'h43);
          vrun = 0;
        end
      end
      pg = bus.o_grant;
    end
  end

  task automatic cpu_xfer(input bit we, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit tail, output logic [31:0] rdt, output int lat, output int wen,
                          output logic [3:0] wev, output int acks);
    bit got;
    got = 0; lat = 0; wen = 0; wev = '0; acks = 0; rdt = 'x;
    bus.i_wb_cyc = 1; bus.i_wb_we = we; bus.i_wb_adr = a; bus.i_wb_dat = d; bus.i_wb_sel = s;
    while (!got && lat < 60) begin
      tick(); lat++;
      if (bus.o_ram_we != 0) begin wen++; wev = bus.o_ram_we; end
      if (bus.o_wb_ack) begin got = 1; acks++; rdt = bus.o_wb_rdt; end
    end
    if (!got) chk("cpu_timeout", 32'd0, 32'd1);
    bus.i_wb_cyc = 0; bus.i_wb_we = 0;
    if (tail) repeat (3) begin
      tick(); acks += int'(bus.o_wb_ack);
      if (bus.o_ram_we != 0) wen++;
    end
  endtask

  task automatic vpu_xfer(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit tail, output logic [31:0] rdt, output int lat,
                          output int wen, output logic [3:0] wev, output int acks);
    bit got;
    got = 0; lat = 0; wen = 0; wev = '0; acks = 0; rdt = 'x;
    bus.i_vpu_request_rd = rd; bus.i_vpu_request_wr = wr;
    bus.i_vpu_adr = a; bus.i_vpu_dat = d; bus.i_vpu_sel = s;
    while (!got && lat < 60) begin
      tick(); lat++;
      if (bus.o_ram_we != 0) begin wen++; wev = bus.o_ram_we; end
      if (bus.o_vpu_ack) begin got = 1; acks++; rdt = bus.o_vpu_rdt; end
    end
    if (!got) chk("vpu_timeout", 32'd0, 32'd1);
    bus.i_vpu_request_rd = 0; bus.i_vpu_request_wr = 0;
    if (tail) repeat (3) begin
      tick(); acks += int'(bus.o_vpu_ack);
      if (bus.o_ram_we != 0) wen++;
    end
  endtask

  task automatic cpu0_xfer(input bit we, input logic [7:0] a, input logic [31:0] d,
                           output logic [31:0] rdt, output int lat);
    bit got;
    got = 0; lat = 0; rdt = 'x;
    bus0.i_wb_cyc = 1; bus0.i_wb_we = we; bus0.i_wb_adr = a; bus0.i_wb_dat = d; bus0.i_wb_sel = 4'hF;
    while (!got && lat < 60) begin
      tick(); lat++;
      if (bus0.o_wb_ack) begin got = 1; rdt = bus0.o_wb_rdt; end
    end
    if (!got) chk("cpu0_timeout", 32'd0, 32'd1);
    bus0.i_wb_cyc = 0; bus0.i_wb_we = 0;
    tick();
  endtask

  initial begin
    logic [31:0] r;
    int lat, wen, acks;
    logic [3:0] wev;
    string exp_s;

    bus.i_wb_cyc = 0; bus.i_wb_we = 0; bus.i_wb_adr = '0; bus.i_wb_dat = '0; bus.i_wb_sel = '0;
    bus.i_vpu_request_rd = 0; bus.i_vpu_request_wr = 0;
    bus.i_vpu_adr = '0; bus.i_vpu_dat = '0; bus.i_vpu_sel = '0;
    bus0.i_wb_cyc = 0; bus0.i_wb_we = 0; bus0.i_wb_adr = '0; bus0.i_wb_dat = '0; bus0.i_wb_sel = '0;
    bus0.i_vpu_request_rd = 1; bus0.i_vpu_request_wr = 1;
    bus0.i_vpu_adr = 8'h03; bus0.i_vpu_dat = 32'hFFFF_FFFF; bus0.i_vpu_sel = 4'hF;

    #1 rst_n = 0;
    #1;
    chk("rst_wb_ack", 32'(bus.o_wb_ack), 32'd0);
    chk("rst_vpu_ack", 32'(bus.o_vpu_ack), 32'd0);
    chk("rst_ram_we", 32'(bus.o_ram_we), 32'd0);
    chk("rst_grant", 32'(bus.o_grant), 32'd0);
    tick(); tick();
    rst_n = 1;
    tick();

    cpu_xfer(1, 8'h04, 32'hDEADBEEF, 4'hF, 1, r, lat, wen, wev, acks);
    chk("cpu_wr_lat", 32'(lat), 32'd2);
    chk("cpu_wr_we_cycles", 32'(wen), 32'd1);
    chk("cpu_wr_we", 32'(wev), 32'hF);
    chk("cpu_wr_acks", 32'(acks), 32'd1);
    cpu_xfer(0, 8'h04, 32'h0, 4'hF, 1, r, lat, wen, wev, acks);
    chk("cpu_rd_lat", 32'(lat), 32'd2);
    chk("cpu_rd_data", r, 32'hDEADBEEF);
    chk("cpu_rd_no_we", 32'(wen), 32'd0);

    vpu_xfer(0, 1, 8'h04, 32'h0000AB00, 4'h2, 1, r, lat, wen, wev, acks);
    chk("vpu_byte_lat", 32'(lat), 32'd2);
    chk("vpu_byte_we", 32'(wev), 32'h2);
    chk("vpu_byte_acks", 32'(acks), 32'd1);
    cpu_xfer(0, 8'h04, 32'h0, 4'hF, 1, r, lat, wen, wev, acks);
    chk("byte_readback", r, 32'hDEADABEF);

    vpu_xfer(1, 1, 8'h08, 32'h12345678, 4'hF, 1, r, lat, wen, wev, acks);
    chk("rdwr_acks", 32'(acks), 32'd1);
    chk("rdwr_we_cycles", 32'(wen), 32'd1);
    chk("rdwr_we", 32'(wev), 32'hF);
    vpu_xfer(1, 0, 8'h08, 32'h0, 4'hF, 1, r, lat, wen, wev, acks);
    chk("rdwr_readback", r, 32'h12345678);

    // both requesters held continuously
    glog.delete();
    fork
      begin
        logic [31:0] r1; int l1, w1, a1; logic [3:0] v1;
        repeat (2) cpu_xfer(0, 8'($urandom_range(0, 15)), 32'h0, 4'hF, 0, r1, l1, w1, v1, a1);
      end
      begin
        logic [31:0] r2; int l2, w2, a2; logic [3:0] v2;
        repeat (8) vpu_xfer(0, 1, 8'($urandom_range(16, 31)), $urandom, 4'hF, 0, r2, l2, w2, v2, a2);
      end
    join
    exp_s = "VVVVCVVVVC";
    chk("order_len", 32'(glog.size()), 32'd10);
    for (int i = 0; i < 10 && i < glog.size(); i++) chk($sformatf("order_%0d", i), 32'(glog[i]), 32'(exp_s[i]));
    tick(); tick();

    // asynchronous reset while a CPU write sits in CPU_CMD
    bus.i_wb_cyc = 1; bus.i_wb_we = 1; bus.i_wb_adr = 8'h0C; bus.i_wb_dat = 32'h55AA55AA; bus.i_wb_sel = 4'hF;
    tick();
    chk("arst_pre_we", 32'(bus.o_ram_we), 32'hF);
    #1 rst_n = 0;
    #1;
    chk("arst_we", 32'(bus.o_ram_we), 32'd0);
    chk("arst_grant", 32'(bus.o_grant), 32'd0);
    acks = 0;
    repeat (2) begin tick(); acks += int'(bus.o_wb_ack); end
    chk("arst_noack", 32'(acks), 32'd0);
    rst_n = 1;
    cpu_xfer(1, 8'h0C, 32'h55AA55AA, 4'hF, 1, r, lat, wen, wev, acks);
    chk("arst_reserve_lat", 32'(lat), 32'd2);
    chk("arst_reserve_acks", 32'(acks), 32'd1);
    cpu_xfer(0, 8'h0C, 32'h0, 4'hF, 1, r, lat, wen, wev, acks);
    chk("arst_readback", r, 32'h55AA55AA);

    // VPU port disabled: VPU request held since time zero
    cpu0_xfer(1, 8'h03, 32'hCAFEF00D, r, lat);
    chk("novpu_wr_lat", 32'(lat), 32'd2);
    cpu0_xfer(0, 8'h03, 32'h0, r, lat);
    chk("novpu_rd_lat", 32'(lat), 32'd2);
    chk("novpu_rd_data", r, 32'hCAFEF00D);

    // random mixed traffic, scored by the memory model
    fork
      begin
        logic [31:0] r1; int l1, w1, a1; logic [3:0] v1;
        repeat (40) begin
          repeat ($urandom_range(0, 3)) tick();
          cpu_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom,
                   4'($urandom_range(1, 15)), 0, r1, l1, w1, v1, a1);
        end
      end
      begin
        logic [31:0] r2; int l2, w2, a2; logic [3:0] v2; int k;
        repeat (40) begin
          repeat ($urandom_range(0, 3)) tick();
          k = int'($urandom_range(0, 2));
          vpu_xfer(k != 1, k != 0, 8'($urandom_range(0, 7)), $urandom,
                   4'($urandom_range(1, 15)), 0, r2, l2, w2, v2, a2);
        end
      end
    join
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = exp_mem[i];
      cpu_xfer(0, 8'(i), 32'h0, 4'hF, 0, r, lat, wen, wev, acks);
      chk($sformatf("final_word_%0d", i), r, e);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
